// File: rtl/bcd_time_counter_pkg.sv
// Shared constants and helpers for the BCD timekeeping counter.
// Digit width, standard modulus chains (MM:SS, HH:MM) and parameter helpers.
// Imported by bcd_mod_digit and bcd_time_counter.
package bcd_time_counter_pkg;

  localparam int DIGIT_W = 4;

  // Moduli packed 4 bits per digit, digit 0 in the LSBs.
  // MM:SS -> seconds units 10, seconds tens 6, minutes units 10, minutes tens 6.
  localparam logic [15:0] MODS_MMSS = 16'h6A6A;
  // HH:MM -> minutes units 10, minutes tens 6, hours units 10, hours tens 3.
  localparam logic [15:0] MODS_HHMM = 16'h3A6A;

  typedef logic [DIGIT_W-1:0] digit_t;

  // Modulus of digit idx from a packed modulus word.
  function automatic int mod_of(input logic [31:0] mods, input int idx);
    return int'(mods[idx*DIGIT_W +: DIGIT_W]);
  endfunction

  // Prescaler counter width; a single bit is kept even when PRESCALE is 1.
  function automatic int psc_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/bcd_time_counter_digit.sv
// Single modulo-MOD BCD digit with up/down stepping, clear and validated load.
// Latency: digit updates on the clock edge after step; carry_out is combinational.
// No backpressure: step is a one-cycle strobe, carry_out feeds the next digit's step.
module bcd_mod_digit
  import bcd_time_counter_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   step,
  input  logic   up_dn,
  input  logic   clear,
  input  logic   load,
  input  digit_t load_val,
  output digit_t digit,
  output logic   carry_out
);

  localparam digit_t LAST = digit_t'(MOD - 1);
  localparam digit_t MODV = digit_t'(MOD);

  // Carry when stepping up from the last value, borrow when stepping down from zero.
  assign carry_out = step && (up_dn ? (digit == LAST) : (digit == '0));

  // Digit register: clear beats load beats step; out-of-range loads become zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit <= '0;
    end else if (clear) begin
      digit <= '0;
    end else if (load) begin
      digit <= (load_val >= MODV) ? '0 : load_val;
    end else if (step) begin
      if (up_dn) begin
        digit <= (digit == LAST) ? '0 : digit + digit_t'(1);
      end else begin
        digit <= (digit == '0) ? LAST : digit - digit_t'(1);
      end
    end
  end

endmodule

// File: rtl/bcd_time_counter.sv
// Prescaled multi-digit BCD time counter (up/down, pause, clear, load, wrap pulse).
// Latency: tick, digit update and wrap all appear 1 cycle after prescaler hits PRESCALE-1.
// No backpressure; en low freezes everything. Optional lap hold: TIME_COUNTER_LAP_HOLD_EN.
module bcd_time_counter
  import bcd_time_counter_pkg::*;
#(
  parameter int          NUM_DIGITS = 4,
  parameter int          PRESCALE   = 50000000,
  parameter logic [31:0] DIGIT_MODS = {16'h0000, MODS_MMSS}
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic                        up_dn,
  input  logic                        clear,
  input  logic                        load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] load_val,
  input  logic                        lap,
  output logic [DIGIT_W*NUM_DIGITS-1:0] out,
  output logic                        tick,
  output logic                        wrap
);

  localparam int             PSC_W    = psc_width(PRESCALE);
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

  logic [PSC_W-1:0]              psc;
  logic                          tick_int;
  logic [NUM_DIGITS:0]           chain;
  logic [DIGIT_W*NUM_DIGITS-1:0] live;

  // A count tick fires on the enabled cycle where the prescaler sits at its last value.
  assign tick_int = en && (psc == PSC_LAST);
  assign chain[0] = tick_int;

  // Digit chain: each digit's carry/borrow is the next digit's step, rippling in one cycle.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_mod_digit #(
      .MOD(mod_of(DIGIT_MODS, g))
    ) u_digit (
      .clk      (clk),
      .reset    (reset),
      .step     (chain[g]),
      .up_dn    (up_dn),
      .clear    (clear),
      .load     (load),
      .load_val (load_val[g*DIGIT_W +: DIGIT_W]),
      .digit    (live[g*DIGIT_W +: DIGIT_W]),
      .carry_out(chain[g+1])
    );
  end

  // Prescaler plus registered tick/wrap strobes; clear and load restart the prescaler.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psc  <= '0;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else if (clear || load) begin
      psc  <= '0;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else if (tick_int) begin
      psc  <= '0;
      tick <= 1'b1;
      wrap <= chain[NUM_DIGITS];
    end else begin
      if (en) begin
        psc <= psc + PSC_W'(1);
      end
      tick <= 1'b0;
      wrap <= 1'b0;
    end
  end

`ifdef TIME_COUNTER_LAP_HOLD_EN
  logic                          lap_q;
  logic                          hold;
  logic [DIGIT_W*NUM_DIGITS-1:0] frozen;
  logic                          lap_rise;

  assign lap_rise = lap && !lap_q;

  // Lap hold: each rising edge of lap toggles hold; entering hold snapshots the live digits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lap_q  <= 1'b0;
      hold   <= 1'b0;
      frozen <= '0;
    end else begin
      lap_q <= lap;
      if (clear) begin
        hold <= 1'b0;
      end else if (lap_rise) begin
        hold <= !hold;
        if (!hold) begin
          frozen <= live;
        end
      end
    end
  end

  assign out = hold ? frozen : live;
`else
  logic lap_unused;
  assign lap_unused = lap;
  assign out        = live;
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Randomized and directed bench for bcd_time_counter against a value-level reference model.
// The model tracks the count as an integer in [0, product of moduli) and converts to BCD.
// Build with TIME_COUNTER_LAP_HOLD_EN defined to also exercise the lap hold path.
module tb_bcd_time_counter;

  localparam int          ND   = 2;
  localparam int          P    = 4;
  localparam logic [31:0] MODS = 32'h0000006A;

  logic        clk = 1'b0;
  logic        reset, en, up_dn, clear, load, lap;
  logic [7:0]  load_val;
  logic [7:0]  out;
  logic        tick, wrap;

  always #5 clk = ~clk;

  bcd_time_counter #(
    .NUM_DIGITS(ND),
    .PRESCALE  (P),
    .DIGIT_MODS(MODS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .up_dn   (up_dn),
    .clear   (clear),
    .load    (load),
    .load_val(load_val),
    .lap     (lap),
    .out     (out),
    .tick    (tick),
    .wrap    (wrap)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mods_v = MODS;
  int  m_v, m_cnt, m_frozen;
  bit  m_tick, m_wrap, m_hold, m_lap_prev;

  function automatic int dmod(input int i);
    return int'(mods_v[4*i +: 4]);
  endfunction

  function automatic int range_total();
    int t = 1;
    for (int i = 0; i < ND; i++) t *= dmod(i);
    return t;
  endfunction

  function automatic logic [7:0] to_bcd(input int value);
    logic [7:0] r = '0;
    int v = value;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(v % dmod(i));
      v = v / dmod(i);
    end
    return r;
  endfunction

  function automatic int from_load(input logic [7:0] lv);
    int v = 0;
    int w = 1;
    logic [7:0] t = lv;
    for (int i = 0; i < ND; i++) begin
      if (int'(t[4*i +: 4]) < dmod(i)) v += int'(t[4*i +: 4]) * w;
      w *= dmod(i);
    end
    return v;
  endfunction

  task automatic model_reset();
    m_v = 0; m_cnt = 0; m_tick = 0; m_wrap = 0;
    m_hold = 0; m_frozen = 0; m_lap_prev = 0;
  endtask

  task automatic model_edge();
    int old_v = m_v;
    int tot = range_total();
    if (clear) begin
      m_v = 0; m_cnt = 0; m_tick = 0; m_wrap = 0;
    end else if (load) begin
      m_v = from_load(load_val); m_cnt = 0; m_tick = 0; m_wrap = 0;
    end else if (en && m_cnt == P - 1) begin
      m_cnt  = 0;
      m_tick = 1;
      if (up_dn) begin
        m_wrap = (m_v == tot - 1);
        m_v    = (m_v + 1) % tot;
      end else begin
        m_wrap = (m_v == 0);
        m_v    = (m_v + tot - 1) % tot;
      end
    end else begin
      if (en) m_cnt++;
      m_tick = 0; m_wrap = 0;
    end
`ifdef TIME_COUNTER_LAP_HOLD_EN
    if (clear) m_hold = 0;
    else if (lap && !m_lap_prev) begin
      if (m_hold) m_hold = 0;
      else begin
        m_hold   = 1;
        m_frozen = old_v;
      end
    end
    m_lap_prev = lap;
`endif
  endtask

  function automatic logic [7:0] exp_out();
    return m_hold ? to_bcd(m_frozen) : to_bcd(m_v);
  endfunction

  // One clock: advance the model with the current inputs, then compare just after the edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, ".out"},  out,  exp_out());
    check({tag, ".tick"}, tick, m_tick);
    check({tag, ".wrap"}, wrap, m_wrap);
  endtask

  int wrap_cnt, tick_n, last_tick, first, k;

  initial begin
    reset = 1; en = 0; up_dn = 1; clear = 0; load = 0; load_val = '0; lap = 0;
    model_reset();
    #12;
    check("rst.out",  out,  8'h00);
    check("rst.tick", tick, 1'b0);
    check("rst.wrap", wrap, 1'b0);
    @(negedge clk);
    reset = 0;

    // Count up through a full 00..59 cycle.
    en = 1; up_dn = 1;
    wrap_cnt = 0; tick_n = 0; last_tick = -1;
    for (int i = 0; i < 60 * P; i++) begin
      step("up");
      if (wrap) wrap_cnt++;
      if (tick) begin
        if (last_tick >= 0) check("tick_gap", i - last_tick, P);
        last_tick = i;
        tick_n++;
        if (tick_n == 1)  check("up.first", out, 8'h01);
        if (tick_n == 10) check("up.ten",   out, 8'h10);
      end
    end
    check("up.final", out, 8'h00);
    check("up.wraps", wrap_cnt, 1);
    check("up.ticks", tick_n, 60);

    // Asynchronous reset mid-count at 37.
    load = 1; load_val = 8'h37; step("ld37"); load = 0;
    step("run37");
    #2 reset = 1;
    #1;
    check("arst.out",  out,  8'h00);
    check("arst.tick", tick, 1'b0);
    model_reset();
    @(posedge clk); #1;
    check("arst.hold", out, 8'h00);
    @(negedge clk);
    reset = 0;
    // Prescaler restarts from 0, so the first tick is registered on the P-th edge.
    first = 0;
    for (int i = 1; i <= P + 2; i++) begin
      step("rel");
      if (tick && first == 0) first = i;
    end
    check("rel.first_tick_edge", first, P);

    // Pause at 23 mid-prescale.
    load = 1; load_val = 8'h23; step("ld23"); load = 0;
    step("p1"); step("p2");
    en = 0;
    for (int i = 0; i < 10; i++) step("pause");
    check("pause.out", out, 8'h23);
    en = 1;
    k = 0;
    for (int i = 1; i <= P; i++) begin
      step("resume");
      if (tick && k == 0) k = i;
    end
    check("resume.remaining", k, P - 2);

    // Count down from 00.
    clear = 1; step("clr"); clear = 0;
    up_dn = 0;
    for (int i = 0; i < P; i++) step("dn");
    check("dn.out59",  out,  8'h59);
    check("dn.wrap1",  wrap, 1'b1);
    for (int i = 0; i < P; i++) step("dn2");
    check("dn.out58",  out,  8'h58);
    check("dn.wrap0",  wrap, 1'b0);

    // Load wins over a coinciding tick; invalid digits load as zero.
    clear = 1; step("clr2"); clear = 0;
    up_dn = 1;
    for (int i = 0; i < 3 * P + P - 1; i++) step("pre");
    load = 1; load_val = 8'h7C; step("ldtick"); load = 0;
    check("ldtick.out",  out,  8'h00);
    check("ldtick.tick", tick, 1'b0);
    for (int i = 0; i < P; i++) step("postld");
    clear = 1; load = 1; load_val = 8'h45; step("clrld"); clear = 0; load = 0;
    check("clrld.out", out, 8'h00);

`ifdef TIME_COUNTER_LAP_HOLD_EN
    // Lap hold: freeze at 12 for 20 ticks, release shows live 32.
    load = 1; load_val = 8'h12; step("lapld"); load = 0;
    lap = 1; step("lap1"); lap = 0;
    for (int i = 0; i < 20 * P - 1; i++) begin
      step("lapheld");
      check("lap.frozen", out, 8'h12);
    end
    lap = 1; step("lap2"); lap = 0;
    check("lap.live", out, 8'h32);
    clear = 1; step("lapclr"); clear = 0;
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      en    = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) up_dn = ~up_dn;
      clear = ($urandom_range(0, 199) == 0);
      load  = ($urandom_range(0, 99) == 0);
      load_val = 8'($urandom);
      if ($urandom_range(0, 15) == 0) lap = ~lap;
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
